// File: rtl/player_datapath.sv
// Player ship datapath: clamped vertical position register plus registered VGA pixel writes.
// Optional erase queue for vacated sprite rows is enabled by defining PLAYER_ERASE_EN.
module player_datapath #(
  parameter logic [7:0] X_POS  = 8'd4,
  parameter logic [6:0] Y_MIN  = 7'd0,
  parameter logic [6:0] Y_MAX  = 7'd117,
  parameter logic [6:0] Y_INIT = 7'd58,
  parameter logic [2:0] COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       y_pos_mod,
  input  logic       y_neg_mod,
  input  logic       add_x,
  input  logic [1:0] add_y,
  input  logic       write_en,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic [6:0] y_cur,
  output logic       at_top,
  output logic       at_bottom,
  output logic       erase_busy,
  output logic       erase_ovf
);

  logic       move_up;
  logic       move_dn;
  logic [6:0] y_next;
  logic       draw;
  logic       drain;
  logic [7:0] erase_x;
  logic [6:0] erase_y;

  always_comb begin
    move_up = y_pos_mod & ~y_neg_mod & (y_cur < Y_MAX);
    move_dn = y_neg_mod & ~y_pos_mod & (y_cur > Y_MIN);
    y_next  = y_cur;
    if (move_up)
      y_next = y_cur + 7'd1;
    else if (move_dn)
      y_next = y_cur - 7'd1;
    draw = write_en & (add_y != 2'd3);
  end

  assign at_top    = (y_cur == Y_MIN);
  assign at_bottom = (y_cur == Y_MAX);

  always_ff @(posedge clk) begin
    if (reset)
      y_cur <= Y_INIT;
    else
      y_cur <= y_next;
  end

`ifdef PLAYER_ERASE_EN
  logic [6:0] q_row [2];
  logic [1:0] q_cnt;
  logic       q_half;
  logic       q_ovf;
  logic       pop;
  logic       push;
  logic       drop;
  logic [6:0] push_row;

  // q_half marks that the head row's left pixel has already been written
  always_comb begin
    drain    = ~write_en & (q_cnt != 2'd0);
    pop      = drain & q_half;
    push     = move_up | move_dn;
    push_row = move_up ? y_cur : y_cur + 7'd2;
    drop     = push & (q_cnt == 2'd2) & ~pop;
    erase_x  = X_POS + {7'b0, q_half};
    erase_y  = q_row[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_row[0] <= '0;
      q_row[1] <= '0;
      q_cnt    <= '0;
      q_half   <= 1'b0;
      q_ovf    <= 1'b0;
    end else begin
      if (drain)
        q_half <= ~q_half;
      if (drop)
        q_ovf <= 1'b1;
      case ({push & ~drop, pop})
        2'b10: begin
          q_row[q_cnt[0]] <= push_row;
          q_cnt           <= q_cnt + 2'd1;
        end
        2'b01: begin
          q_row[0] <= q_row[1];
          q_cnt    <= q_cnt - 2'd1;
        end
        2'b11: begin
          // simultaneous pop and push: occupancy unchanged, new row goes behind any survivor
          if (q_cnt == 2'd1) begin
            q_row[0] <= push_row;
          end else begin
            q_row[0] <= q_row[1];
            q_row[1] <= push_row;
          end
        end
        default: ;
      endcase
    end
  end

  assign erase_busy = (q_cnt != 2'd0);
  assign erase_ovf  = q_ovf;
`else
  assign drain      = 1'b0;
  assign erase_x    = '0;
  assign erase_y    = '0;
  assign erase_busy = 1'b0;
  assign erase_ovf  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      x_out  <= '0;
      y_out  <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else if (draw) begin
      x_out  <= X_POS + {7'b0, add_x};
      y_out  <= y_next + {5'b0, add_y};
      colour <= COLOUR;
      plot   <= 1'b1;
    end else if (drain) begin
      x_out  <= erase_x;
      y_out  <= erase_y;
      colour <= '0;
      plot   <= 1'b1;
    end else begin
      plot <= 1'b0;
    end
  end

endmodule

// File: tb/tb_player_datapath.sv
// Self-checking bench for player_datapath: pixel-queue reference model checked every cycle,
// plus directed literal checks. Define PLAYER_ERASE_EN to also exercise the erase queue.
module tb_player_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       y_pos_mod, y_neg_mod, add_x, write_en;
  logic [1:0] add_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic [6:0] y_cur;
  logic       at_top, at_bottom, erase_busy, erase_ovf;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

`ifdef PLAYER_ERASE_EN
  localparam bit ERASE = 1'b1;
`else
  localparam bit ERASE = 1'b0;
`endif

  player_datapath #(
    .X_POS (8'd4),
    .Y_MIN (7'd0),
    .Y_MAX (7'd117),
    .Y_INIT(7'd58),
    .COLOUR(3'b111)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .y_pos_mod (y_pos_mod),
    .y_neg_mod (y_neg_mod),
    .add_x     (add_x),
    .add_y     (add_y),
    .write_en  (write_en),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour    (colour),
    .plot      (plot),
    .y_cur     (y_cur),
    .at_top    (at_top),
    .at_bottom (at_bottom),
    .erase_busy(erase_busy),
    .erase_ovf (erase_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: pending erase work is a plain queue of pixels, two per vacated row
  typedef struct { int x; int y; } pix_t;
  pix_t m_q[$];
  pix_t m_p;
  int   m_y, m_xo, m_yo, m_col, m_ny;
  bit   m_plot, m_ovf, m_up, m_dn, m_drain, m_completing, m_full;

  always @(posedge clk) begin
    if (reset) begin
      m_y = 58; m_xo = 0; m_yo = 0; m_col = 0; m_plot = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      m_up = y_pos_mod && !y_neg_mod && m_y < 117;
      m_dn = y_neg_mod && !y_pos_mod && m_y > 0;
      m_ny = m_y + (m_up ? 1 : 0) - (m_dn ? 1 : 0);
      m_drain = ERASE && !write_en && m_q.size() > 0;
      m_completing = m_drain && (m_q.size() % 2 == 1);
      m_full = m_q.size() >= 3;
      if (write_en && add_y != 2'd3) begin
        m_xo = 4 + int'(add_x); m_yo = m_ny + int'(add_y); m_col = 7; m_plot = 1;
      end else if (write_en) begin
        m_plot = 0;
      end else if (m_drain) begin
        m_p = m_q.pop_front();
        m_xo = m_p.x; m_yo = m_p.y; m_col = 0; m_plot = 1;
      end else begin
        m_plot = 0;
      end
      if (ERASE && (m_up || m_dn)) begin
        if (m_full && !m_completing) begin
          m_ovf = 1;
        end else begin
          m_q.push_back('{4, m_up ? m_y : m_y + 2});
          m_q.push_back('{5, m_up ? m_y : m_y + 2});
        end
      end
      m_y = m_ny;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_plot", plot, m_plot);
      if (m_plot) begin
        chk("m_x_out", x_out, m_xo);
        chk("m_y_out", y_out, m_yo);
        chk("m_colour", colour, m_col);
      end
      chk("m_y_cur", y_cur, m_y);
      chk("m_at_top", at_top, m_y == 0);
      chk("m_at_bottom", at_bottom, m_y == 117);
      chk("m_erase_busy", erase_busy, m_q.size() > 0);
      chk("m_erase_ovf", erase_ovf, m_ovf);
    end
  end

  task automatic step(input bit up, input bit dn, input bit we, input bit ax, input bit [1:0] ay);
    y_pos_mod = up; y_neg_mod = dn; write_en = we; add_x = ax; add_y = ay;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic expect_pix(input string name, input int x, input int y, input int c);
    chk({name, "_plot"}, plot, 1);
    chk({name, "_x"}, x_out, x);
    chk({name, "_y"}, y_out, y);
    chk({name, "_colour"}, colour, c);
  endtask

  initial begin
    reset = 1'b1;
    y_pos_mod = 0; y_neg_mod = 0; write_en = 0; add_x = 0; add_y = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_en = 1'b1;

    chk("rst_y_cur", y_cur, 58);
    chk("rst_plot", plot, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_colour", colour, 0);
    chk("rst_busy", erase_busy, 0);
    chk("rst_ovf", erase_ovf, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    chk("idle_plot", plot, 0);
    chk("idle_x_out", x_out, 0);
    chk("idle_y_out", y_out, 0);

    // Up move with the first pixel, then the rest of the sprite
    step(1, 0, 1, 0, 0); expect_pix("up0", 4, 59, 7);
    chk("up_y_cur", y_cur, 59);
    step(0, 0, 1, 1, 0); expect_pix("up1", 5, 59, 7);
    step(0, 0, 1, 0, 1); expect_pix("up2", 4, 60, 7);
    step(0, 0, 1, 1, 1); expect_pix("up3", 5, 60, 7);
    step(0, 0, 1, 0, 2); expect_pix("up4", 4, 61, 7);
    step(0, 0, 1, 1, 2); expect_pix("up5", 5, 61, 7);
    chk("up_y_cur_end", y_cur, 59);
    step(0, 0, 1, 1, 3);
    chk("suppressed_plot", plot, 0);
    chk("suppressed_y_cur", y_cur, 59);

    // Climb to the bottom limit, let any erase work drain, then clamp
    for (int i = 0; i < 60; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    chk("climb_y_cur", y_cur, 117);
    step(1, 0, 1, 0, 0);
    expect_pix("clamp_bot", 4, 117, 7);
    chk("clamp_bot_y_cur", y_cur, 117);
    chk("clamp_bot_flag", at_bottom, 1);
    chk("clamp_bot_busy", erase_busy, 0);

    // Descend to the top limit and clamp there
    for (int i = 0; i < 120; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 2);
    expect_pix("clamp_top", 5, 2, 7);
    chk("clamp_top_y_cur", y_cur, 0);
    chk("clamp_top_flag", at_top, 1);
    chk("clamp_top_busy", erase_busy, 0);

    // Both strobes: no move
    do_reset();
    step(1, 1, 1, 0, 0);
    expect_pix("both", 4, 58, 7);
    chk("both_y_cur", y_cur, 58);
    chk("both_busy", erase_busy, 0);

    // Down move from reset position
    do_reset();
    step(0, 1, 1, 0, 0); expect_pix("dn0", 4, 57, 7);
    chk("dn_y_cur", y_cur, 57);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 2);
    step(0, 0, 1, 1, 2); expect_pix("dn5", 5, 59, 7);
`ifdef PLAYER_ERASE_EN
    chk("dn_busy_pending", erase_busy, 1);
    step(0, 0, 0, 0, 0); expect_pix("erase0", 4, 60, 0);
    chk("erase0_busy", erase_busy, 1);
    step(0, 0, 0, 0, 0); expect_pix("erase1", 5, 60, 0);
    chk("erase1_busy", erase_busy, 0);
    step(0, 0, 0, 0, 0);
    chk("erase_done_plot", plot, 0);

    // Overflow: three moves with no idle cycle between them
    do_reset();
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("ovf_before", erase_ovf, 0);
    step(1, 0, 1, 0, 0);
    chk("ovf_flag", erase_ovf, 1);
    chk("ovf_y_cur", y_cur, 61);
    chk("ovf_busy", erase_busy, 1);
    step(0, 0, 0, 0, 0); expect_pix("ovf_erase0", 4, 58, 0);
    do_reset();
    chk("rst2_y_cur", y_cur, 58);
    chk("rst2_busy", erase_busy, 0);
    chk("rst2_ovf", erase_ovf, 0);
    chk("rst2_plot", plot, 0);
    step(0, 0, 0, 0, 0);
    chk("rst2_no_pending", plot, 0);
`else
    step(0, 0, 0, 0, 0);
    chk("dn_idle_plot", plot, 0);
    chk("dn_idle_busy", erase_busy, 0);
`endif
    step(0, 0, 0, 0, 0);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/player_datapath.md
# player_datapath

Datapath stage directly downstream of the player sequencing FSM. Owns the player ship's vertical position register, applies the FSM's move strobes with clamping, and turns each per-pixel offset (add_x, add_y, write_en) into a registered VGA pixel write (x, y, colour, plot). Optionally queues erase writes for the sprite row vacated by a move and emits them in idle cycles.

## Interface
Parameters:
- X_POS, 8'd4: fixed left column of the 2-wide ship
- Y_MIN, 7'd0: lowest legal top-row y
- Y_MAX, 7'd117: highest legal top-row y; must be ≤ 125
- Y_INIT, 7'd58: y after reset
- COLOUR, 3'b111: draw colour

Ports:
- clk  in  1  system clock (60 Hz frame-tick domain)
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- y_pos_mod  in  1  increment y by 1 this cycle
- y_neg_mod  in  1  decrement y by 1 this cycle
- add_x  in  1  column offset of current pixel (0/1)
- add_y  in  2  row offset of current pixel (0..2)
- write_en  in  1  current pixel is valid
- x_out  out  8  VGA x
- y_out  out  7  VGA y
- colour  out  3  VGA colour
- plot  out  1  VGA write strobe
- y_cur  out  7  current top-row y
- at_top  out  1  y_cur == Y_MIN
- at_bottom  out  1  y_cur == Y_MAX
- erase_busy  out  1  erase queue non-empty (0 when erase compiled out)
- erase_ovf  out  1  sticky: an erase was dropped (0 when erase compiled out)

## Operation
- Move: y_next = y_cur+1 if y_pos_mod & !y_neg_mod & y_cur < Y_MAX; y_cur−1 if y_neg_mod & !y_pos_mod & y_cur > Y_MIN; else y_cur. y_cur <= y_next each clock.
- Both strobes high: no move, no erase queued.
- Clamped strobe (at Y_MAX up / Y_MIN down): no move, no erase queued; pixel writes still issued at y_cur.
- Draw pixel: when write_en=1 and add_y ≠ 3: x_out <= X_POS + add_x, y_out <= y_next + add_y, colour <= COLOUR, plot <= 1. Uses y_next, so the pixel issued with the move strobe lands at the new position.
- add_y = 3 with write_en=1: pixel suppressed (plot <= 0), no other effect.
- at_top/at_bottom combinational from y_cur.

## Timing
- Latency: write_en at cycle N -> plot/x_out/y_out/colour valid cycle N+1; y_cur reflects a move at N+1.
- Outputs registered; plot is a single-cycle pulse per accepted pixel.
- Reset values: y_cur=Y_INIT, x_out=0, y_out=0, colour=0, plot=0, erase_busy=0, erase_ovf=0, erase queue empty.
- Reset mid-move or mid-erase: position restored to Y_INIT, queue flushed, no pending write emitted after reset deasserts.
- Draw writes have strict priority; erase writes only in cycles with write_en=0.

## Configuration
- PLAYER_ERASE_EN defined: 2-row-deep erase queue. Each accepted move enqueues the vacated row: old y_cur on increment, old y_cur+2 on decrement. Each row drains as two writes, x=X_POS then X_POS+1, colour=3'b000, one per idle cycle (write_en=0), same 1-cycle register stage as draws. Enqueue and drain of the same row slot in one cycle both take effect. Move with queue full (2 rows pending, none completing that cycle): move still applied, its erase row dropped, erase_ovf set until reset. erase_busy=1 while any row or half-row is pending.
- PLAYER_ERASE_EN undefined: no queue; plot is draws only; erase_busy and erase_ovf tied 0.

## Test plan
- Reset, then idle: y_cur=58, plot=0 and all outputs 0 until first write_en.
- Up sequence: y_pos_mod+write_en at cycle 1, then five write_en pixels (add_x/add_y 1/0, 0/1, 1/1, 0/2, 1/2) -> six plots cycles 2..7 at (4,59),(5,59),(4,60),(5,60),(4,61),(5,61), colour 7; y_cur=59.
- Clamp: force y_cur to 117, assert y_pos_mod -> y_cur stays 117, at_bottom=1, draw at y=117, no erase queued.
- Both strobes high at y=58 -> y_cur 58, pixel drawn at y=58.
- PLAYER_ERASE_EN: down move from 58, then 6 draw cycles, then idle -> erase writes (4,60),(5,60) colour 0 in first two idle cycles; erase_busy falls after the second.
- PLAYER_ERASE_EN: three back-to-back moves with no idle cycles -> third erase dropped, erase_ovf=1; reset mid-drain clears queue and flag, y_cur=58.
